// File: rtl/loa_shared_adder_arbiter.sv
// Round-robin shared lower-part-OR approximate adder: one operand pair is granted per cycle,
// and each result is registered once, tagged with the owning requester, and drained on valid/ready.
module loa_shared_adder_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_BITS   = 2,
    parameter int LOWER_MAX = 16,
    parameter int LW_BITS   = 5,
    parameter int CNT_BITS  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*WIDTH-1:0]   add1_i,
    input  logic [NUM_REQ*WIDTH-1:0]   add2_i,
    input  logic [LW_BITS-1:0]         lower_width_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH:0]             result_o,
    output logic [ID_BITS-1:0]         id_o,
    output logic [LW_BITS-1:0]         lw_o,
    output logic [CNT_BITS-1:0]        op_count_o
);

    logic                valid_q, valid_d;
    logic [WIDTH:0]      result_q, result_d;
    logic [ID_BITS-1:0]  id_q, id_d;
    logic [LW_BITS-1:0]  lw_q, lw_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [ID_BITS-1:0]  ptr_q, ptr_d;

    logic                accept;
    logic [NUM_REQ-1:0]  hi_mask;
    logic [NUM_REQ-1:0]  req_hi;
    logic [ID_BITS-1:0]  gidx;

    assign accept = ~rst_i & (~valid_q | ready_i) & (|req_i);

    // Requests at or above the pointer take priority; otherwise the search wraps to bit 0.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign hi_mask[gi] = (ptr_q <= ID_BITS'(gi));
        assign gnt_o[gi]   = accept & (gidx == ID_BITS'(gi));
    end
    assign req_hi = req_i & hi_mask;

    always_comb begin
        gidx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) gidx = ID_BITS'(i);
        end
        if (|req_hi) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_hi[i]) gidx = ID_BITS'(i);
            end
        end
    end

    logic [WIDTH-1:0]   op_a, op_b, low_mask, low_top, a_hi, b_hi;
    logic [LW_BITS-1:0] lw_clamp;
    logic               cin;
    logic [WIDTH:0]     sum_hi, loa_sum;

    always_comb begin
        op_a     = add1_i[gidx*WIDTH +: WIDTH];
        op_b     = add2_i[gidx*WIDTH +: WIDTH];
        lw_clamp = (lower_width_i > LW_BITS'(LOWER_MAX)) ? LW_BITS'(LOWER_MAX) : lower_width_i;
        low_mask = ~({WIDTH{1'b1}} << lw_clamp);
        // Isolates bit lw-1 of the lower part; empty when lw is zero, giving a zero carry-in.
        low_top  = low_mask & ~(low_mask >> 1);
        cin      = |(op_a & op_b & low_top);
        a_hi     = op_a >> lw_clamp;
        b_hi     = op_b >> lw_clamp;
        sum_hi   = {1'b0, a_hi} + {1'b0, b_hi} + {{WIDTH{1'b0}}, cin};
        loa_sum  = (sum_hi << lw_clamp) | {1'b0, (op_a | op_b) & low_mask};
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        id_d     = id_q;
        lw_d     = lw_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = loa_sum;
            id_d     = gidx;
            lw_d     = lw_clamp;
            cnt_d    = cnt_q + 1'b1;
            ptr_d    = (gidx == ID_BITS'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            id_q     <= '0;
            lw_q     <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            id_q     <= id_d;
            lw_q     <= lw_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign id_o       = id_q;
    assign lw_o       = lw_q;
    assign op_count_o = cnt_q;

endmodule

// File: tb/tb_loa_shared_adder_arbiter.sv
// Directed bench for loa_shared_adder_arbiter: hand-computed vectors covering grants,
// the approximate sum, backpressure, round-robin order, and asynchronous reset.
module tb_loa_shared_adder_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_i;
    logic [127:0] add1_i;
    logic [127:0] add2_i;
    logic [4:0]   lower_width_i;
    logic [3:0]   gnt_o;
    logic         valid_o;
    logic         ready_i;
    logic [32:0]  result_o;
    logic [1:0]   id_o;
    logic [4:0]   lw_o;
    logic [15:0]  op_count_o;

    int vectors     = 0;
    int miscompares = 0;

    loa_shared_adder_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .add1_i        (add1_i),
        .add2_i        (add2_i),
        .lower_width_i (lower_width_i),
        .gnt_o         (gnt_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o),
        .id_o          (id_o),
        .lw_o          (lw_o),
        .op_count_o    (op_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
            $display("vec %0d %s observed=%0h", vectors, tag, obs);
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
        add1_i[k*32 +: 32] = a;
        add2_i[k*32 +: 32] = b;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 4'b0001; ready_i = 1'b1; lower_width_i = 5'd0;
        add1_i = '0; add2_i = '0;
        #2;
        check("rst_gnt", 64'(gnt_o), 64'h0);
        tick();
        check("rst_valid", 64'(valid_o), 64'h0);
        check("rst_result", 64'(result_o), 64'h0);
        check("rst_count", 64'(op_count_o), 64'h0);
        rst_i = 1'b0;

        // Approximate add, lw=8
        set_ops(0, 32'h0000_00FF, 32'h0000_0081); lower_width_i = 5'd8; req_i = 4'b0001;
        #1 check("t1_gnt", 64'(gnt_o), 64'h1);
        tick();
        check("t1_valid", 64'(valid_o), 64'h1);
        check("t1_result", 64'(result_o), 64'h1FF);
        check("t1_id", 64'(id_o), 64'h0);
        check("t1_lw", 64'(lw_o), 64'h8);

        // Exact adds, lw=0 (pointer is 1, search wraps to requester 0)
        lower_width_i = 5'd0;
        #1 check("t2_gnt", 64'(gnt_o), 64'h1);
        tick();
        check("t2_result", 64'(result_o), 64'h180);
        set_ops(0, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        check("t2_carry", 64'(result_o), 64'h1_0000_0000);
        check("t2_count", 64'(op_count_o), 64'h3);

        // Clamping to 16; carry-in from bit 15 reaches the upper part
        set_ops(0, 32'h0000_FFFF, 32'h0000_FFFF); lower_width_i = 5'd31;
        tick();
        check("t5_lw", 64'(lw_o), 64'h10);
        check("t5_result", 64'(result_o), 64'h1_FFFF);
        set_ops(0, 32'h0001_8000, 32'h0001_8000); lower_width_i = 5'd16;
        tick();
        check("t5_result2", 64'(result_o), 64'h3_8000);
        req_i = 4'b0000;
        tick();
        check("drain_valid", 64'(valid_o), 64'h0);
        check("drain_hold", 64'(result_o), 64'h3_8000);

        // Round-robin after a fresh reset
        #1 rst_i = 1'b1;
        #1 check("rr_rst_count", 64'(op_count_o), 64'h0);
        rst_i = 1'b0;
        lower_width_i = 5'd0;
        for (int k = 0; k < 4; k++) set_ops(k, 32'(k + 1), 32'h10);
        req_i = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1 check($sformatf("rr_gnt%0d", n), 64'(gnt_o), 64'(4'b0001 << (n % 4)));
            tick();
            check($sformatf("rr_id%0d", n), 64'(id_o), 64'(n % 4));
            check($sformatf("rr_res%0d", n), 64'(result_o), 64'((n % 4) + 32'h11));
        end
        check("rr_count", 64'(op_count_o), 64'h5);

        // Backpressure: result of requester 0 held while ready_i=0
        req_i = 4'b0010; ready_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1 check($sformatf("bp_gnt%0d", n), 64'(gnt_o), 64'h0);
            tick();
            check($sformatf("bp_res%0d", n), 64'(result_o), 64'h11);
            check($sformatf("bp_valid%0d", n), 64'(valid_o), 64'h1);
        end
        ready_i = 1'b1;
        #1 check("bp_release_gnt", 64'(gnt_o), 64'h2);
        tick();
        check("bp_release_id", 64'(id_o), 64'h1);
        check("bp_release_res", 64'(result_o), 64'h12);
        check("bp_count", 64'(op_count_o), 64'h6);

        // Asynchronous reset with valid_o=1 and pointer at 2, no clock edge involved
        req_i = 4'b0000;
        #1 rst_i = 1'b1;
        #1 check("ar_valid", 64'(valid_o), 64'h0);
        check("ar_count", 64'(op_count_o), 64'h0);
        check("ar_result", 64'(result_o), 64'h0);
        rst_i = 1'b0;
        req_i = 4'b1111;
        #1 check("ar_gnt", 64'(gnt_o), 64'h1);
        tick();
        check("ar_id", 64'(id_o), 64'h0);
        check("ar_count2", 64'(op_count_o), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
